// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 single divider: 27-cycle radix-2 restoring mantissa divide plus one round/pack cycle.
// Specials resolve in one cycle; a single operation is in flight and the result holds in DONE until out_ready.
module fdiv_iter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  input  logic [31:0] t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t       state_q, state_d;
  logic         sign_q, sign_d;
  logic [7:0]   es_q, es_d, et_q, et_d;
  logic [24:0]  rem_q, rem_d;
  logic [23:0]  mt_q, mt_d;
  logic [26:0]  quo_q, quo_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [31:0]  d_q, d_d;
  logic         ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;

  logic s_zero, s_inf, s_nan, t_zero, t_inf, t_nan, sign_in;
  logic is_special, spec_dbz;
  logic [31:0] spec_res;

  assign sign_in = s[31] ^ t[31];
  assign s_zero  = (s[30:23] == 8'h00);
  assign t_zero  = (t[30:23] == 8'h00);
  assign s_inf   = (s[30:23] == 8'hFF) && (s[22:0] == 23'd0);
  assign t_inf   = (t[30:23] == 8'hFF) && (t[22:0] == 23'd0);
  assign s_nan   = (s[30:23] == 8'hFF) && (s[22:0] != 23'd0);
  assign t_nan   = (t[30:23] == 8'hFF) && (t[22:0] != 23'd0);

  // Exponent field of zero means zero: denormal inputs are flushed here.
  always_comb begin
    spec_res   = 32'h0;
    spec_dbz   = 1'b0;
    is_special = 1'b1;
    if (s_nan)                                  spec_res = {s[31], 8'hFF, 1'b1, s[21:0]};
    else if (t_nan)                             spec_res = {t[31], 8'hFF, 1'b1, t[21:0]};
    else if ((s_inf && t_inf) || (s_zero && t_zero)) spec_res = 32'h7FC0_0000;
    else if (s_inf)                             spec_res = {sign_in, 8'hFF, 23'd0};
    else if (t_inf)                             spec_res = {sign_in, 31'd0};
    else if (t_zero) begin
      spec_res = {sign_in, 8'hFF, 23'd0};
      spec_dbz = 1'b1;
    end
    else if (s_zero)                            spec_res = {sign_in, 31'd0};
    else                                        is_special = 1'b0;
  end

  logic        qbit;
  logic [24:0] diff;
  assign qbit = (rem_q >= {1'b0, mt_q});
  assign diff = rem_q - (qbit ? {1'b0, mt_q} : 25'd0);

  logic [23:0]       mant;
  logic              g, r, st, adj, inc, rc;
  logic [22:0]       frac;
  logic signed [9:0] e_res;

  // Quotient lies in (0.5, 2): adj tracks the one-bit renormalisation.
  always_comb begin
    if (quo_q[26]) begin
      mant = quo_q[26:3];
      g    = quo_q[2];
      r    = quo_q[1];
      st   = quo_q[0] | (rem_q != 25'd0);
      adj  = 1'b0;
    end else begin
      mant = quo_q[25:2];
      g    = quo_q[1];
      r    = quo_q[0];
      st   = (rem_q != 25'd0);
      adj  = 1'b1;
    end
    inc   = g & (r | st | mant[0]);
    frac  = mant[22:0] + {22'd0, inc};
    rc    = (&mant) & inc;
    e_res = $signed({2'b00, es_q}) - $signed({2'b00, et_q}) + 10'sd127
            - $signed({9'd0, adj}) + $signed({9'd0, rc});
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    es_d    = es_q;
    et_d    = et_q;
    rem_d   = rem_q;
    mt_d    = mt_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = sign_in;
          es_d   = s[30:23];
          et_d   = t[30:23];
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          dbz_d  = 1'b0;
          if (is_special) begin
            d_d     = spec_res;
            dbz_d   = spec_dbz;
            state_d = DONE;
          end else begin
            rem_d   = {2'b01, s[22:0]};
            mt_d    = {1'b1, t[22:0]};
            quo_d   = 27'd0;
            cnt_d   = 5'd26;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = diff << 1;
        quo_d = {quo_q[25:0], qbit};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = ROUND;
      end
      ROUND: begin
        if (e_res >= 10'sd255) begin
          d_d   = {sign_q, 8'hFF, 23'd0};
          ovf_d = 1'b1;
        end else if (e_res <= 10'sd0) begin
          d_d   = {sign_q, 31'd0};
          unf_d = 1'b1;
        end else begin
          d_d = {sign_q, e_res[7:0], frac};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      es_q    <= 8'd0;
      et_q    <= 8'd0;
      rem_q   <= 25'd0;
      mt_q    <= 24'd0;
      quo_q   <= 27'd0;
      cnt_q   <= 5'd0;
      d_q     <= 32'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      es_q    <= es_d;
      et_q    <= et_d;
      rem_q   <= rem_d;
      mt_q    <= mt_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign d           = d_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Bench for fdiv_iter: directed plan vectors, random operands against a wide-integer reference divider.
module tb_fdiv_iter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] s = 32'd0;
  logic [31:0] t = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] d;
  logic        overflow, underflow, div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  fdiv_iter dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .t(t),
    .out_valid(out_valid), .out_ready(out_ready), .d(d),
    .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  flags;  // {overflow, underflow, div_by_zero}
    int          lat;
  } res_t;

  // Reference: exact quotient with 40 extra fraction bits, then round-to-nearest-even.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t res;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic sgn, az, bz, ai, bi, an, bn;
    longint unsigned num, q, rm, mant, low, half;
    int sh, e;
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    sgn = a[31] ^ b[31];
    az = (ea == 0); bz = (eb == 0);
    ai = (ea == 8'hFF) && (fa == 0); bi = (eb == 8'hFF) && (fb == 0);
    an = (ea == 8'hFF) && (fa != 0); bn = (eb == 8'hFF) && (fb != 0);
    res.flags = 3'b000;
    res.lat = 1;
    if (an)                          res.d = {a[31], 8'hFF, 1'b1, a[21:0]};
    else if (bn)                     res.d = {b[31], 8'hFF, 1'b1, b[21:0]};
    else if ((ai && bi) || (az && bz)) res.d = 32'h7FC00000;
    else if (ai)                     res.d = {sgn, 8'hFF, 23'd0};
    else if (bi)                     res.d = {sgn, 31'd0};
    else if (bz) begin res.d = {sgn, 8'hFF, 23'd0}; res.flags = 3'b001; end
    else if (az)                     res.d = {sgn, 31'd0};
    else begin
      res.lat = 28;
      num = {40'd1, fa} << 40;
      q   = num / {40'd1, fb};
      rm  = num % {40'd1, fb};
      if (q >= (64'd1 << 40)) begin sh = 17; e = int'(ea) - int'(eb) + 127; end
      else                    begin sh = 16; e = int'(ea) - int'(eb) + 126; end
      mant = q >> sh;
      low  = q & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (low > half || (low == half && (rm != 0 || mant[0]))) mant = mant + 1;
      if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e = e + 1; end
      if (e >= 255)    begin res.d = {sgn, 8'hFF, 23'd0}; res.flags = 3'b100; end
      else if (e <= 0) begin res.d = {sgn, 31'd0};        res.flags = 3'b010; end
      else             res.d = {sgn, e[7:0], mant[22:0]};
    end
    return res;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] rnd;
    logic [7:0] e;
    int k;
    rnd = $urandom();
    k = $urandom_range(0, 15);
    case (k)
      0: e = 8'h00;
      1: begin e = 8'hFF; if (rnd[0]) rnd[22:0] = 23'd0; end
      2: e = 8'($urandom_range(240, 254));
      3: e = 8'($urandom_range(1, 14));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {rnd[31], e, rnd[22:0]};
  endfunction

  // Issue one operation and complete its handshake; lat = -1 when nothing comes back.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rd, output logic [2:0] rf, output int lat);
    int w;
    rd = 32'hx; rf = 3'bxxx; lat = -1;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; s = a; t = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
    if (lat > 0) begin
      rd = d; rf = {overflow, underflow, div_by_zero};
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL reset_d: got %h want 00000000", d); end
    vectors++; if ({overflow, underflow, div_by_zero} !== 3'b000) begin miscompares++;
      $display("FAIL reset_flags: got %b want 000", {overflow, underflow, div_by_zero}); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] va [9] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h00000000,
                             32'h7FA00001, 32'h3F800000, 32'h7F000000, 32'h00800000};
    logic [31:0] vb [9] = '{32'h40400000, 32'h40400000, 32'h40400000, 32'h00000000, 32'h00000000,
                             32'h3F800000, 32'hFF800000, 32'h3E800000, 32'h40000000};
    logic [31:0] vd [9] = '{32'h40000000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h7F800000, 32'h7FC00000,
                             32'h7FE00001, 32'h80000000, 32'h7F800000, 32'h00000000};
    logic [2:0]  vf [9] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010};
    int          vl [9] = '{28, 28, 28, 1, 1, 1, 1, 28, 28};
    logic [31:0] rd; logic [2:0] rf; int lat;
    for (int i = 0; i < 9; i++) begin
      do_op(va[i], vb[i], rd, rf, lat);
      vectors++; if (lat !== vl[i]) begin miscompares++;
        $display("FAIL directed_lat[%0d] %h/%h: got %0d want %0d", i, va[i], vb[i], lat, vl[i]); end
      vectors++; if (rd !== vd[i]) begin miscompares++;
        $display("FAIL directed_d[%0d] %h/%h: got %h want %h", i, va[i], vb[i], rd, vd[i]); end
      vectors++; if (rf !== vf[i]) begin miscompares++;
        $display("FAIL directed_flags[%0d] %h/%h: got %b want %b", i, va[i], vb[i], rf, vf[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, rd; logic [2:0] rf; int lat; res_t exp_r;
    for (int i = 0; i < 60; i++) begin
      a = rand_fp(); b = rand_fp();
      exp_r = model(a, b);
      do_op(a, b, rd, rf, lat);
      vectors++; if (lat !== exp_r.lat) begin miscompares++;
        $display("FAIL random_lat %h/%h: got %0d want %0d", a, b, lat, exp_r.lat); end
      vectors++; if (rd !== exp_r.d) begin miscompares++;
        $display("FAIL random_d %h/%h: got %h want %h", a, b, rd, exp_r.d); end
      vectors++; if (rf !== exp_r.flags) begin miscompares++;
        $display("FAIL random_flags %h/%h: got %b want %b", a, b, rf, exp_r.flags); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_idle_ready: got %b want 1", in_ready); end
    in_valid = 1'b1; s = 32'h40C00000; t = 32'h40400000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
    vectors++; if (lat !== 28) begin miscompares++; $display("FAIL bp_lat: got %0d want 28", lat); end
    in_valid = 1'b1; s = 32'h3F800000; t = 32'h40400000;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      vectors++; if (d !== 32'h40000000) begin miscompares++; $display("FAIL bp_hold_d: got %h want 40000000", d); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_ready: got %b want 0", in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_accept_ready: got %b want 0", in_ready); end
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
    vectors++; if (lat !== 28) begin miscompares++; $display("FAIL bp_second_lat: got %0d want 28", lat); end
    vectors++; if (d !== 32'h3EAAAAAB) begin miscompares++; $display("FAIL bp_second_d: got %h want 3EAAAAAB", d); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] qa [6], qb [6];
    res_t exp_q [$];
    int idx, got;
    logic acc;
    for (int i = 0; i < 6; i++) begin
      qa[i] = rand_fp(); qb[i] = rand_fp();
      exp_q.push_back(model(qa[i], qb[i]));
    end
    idx = 0; got = 0;
    s = qa[0]; t = qb[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 400 && got < 6; c++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      if (out_valid) begin
        vectors++; if (d !== exp_q[got].d || {overflow, underflow, div_by_zero} !== exp_q[got].flags) begin
          miscompares++;
          $display("FAIL b2b[%0d] %h/%h: got %h/%b want %h/%b", got, qa[got], qb[got], d,
                   {overflow, underflow, div_by_zero}, exp_q[got].d, exp_q[got].flags);
        end
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 6) begin s = qa[idx]; t = qb[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++; if (got !== 6) begin miscompares++; $display("FAIL b2b_count: got %0d want 6", got); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [2:0] rf; int lat;
    in_valid = 1'b1; s = 32'h40C00000; t = 32'h40400000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL midrst_d: got %h want 00000000", d); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    rstn = 1'b1;
    @(posedge clk); #1;
    do_op(32'h40C00000, 32'h40400000, rd, rf, lat);
    vectors++; if (lat !== 28) begin miscompares++; $display("FAIL midrst_after_lat: got %0d want 28", lat); end
    vectors++; if (rd !== 32'h40000000) begin miscompares++; $display("FAIL midrst_after_d: got %h want 40000000", rd); end
    vectors++; if (rf !== 3'b000) begin miscompares++; $display("FAIL midrst_after_flags: got %b want 000", rf); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
